// File: rtl/instr_encoder_if.sv
// Instruction-in / byte-out bundle between the program loader and the encoder.
// Latency: none (wires only).
// Backpressure: in_ready and out_ready carry the valid/ready handshakes in each direction.
interface instr_encoder_if #(
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_opcode;
    logic [2:0]        in_dst;
    logic [2:0]        in_src1;
    logic [2:0]        in_src2;
    logic              in_hasimm1;
    logic [7:0]        in_imm1;
    logic              in_hasimm2;
    logic [7:0]        in_imm2;
    logic              addr_clr;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_byte;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic [7:0]        illegal_cnt;

    // Loader / host side
    modport master (
        output in_valid, in_opcode, in_dst, in_src1, in_src2,
               in_hasimm1, in_imm1, in_hasimm2, in_imm2, addr_clr, out_ready,
        input  in_ready, out_valid, out_byte, out_addr, out_last, illegal_cnt
    );

    // Encoder side
    modport slave (
        input  in_valid, in_opcode, in_dst, in_src1, in_src2,
               in_hasimm1, in_imm1, in_hasimm2, in_imm2, addr_clr, out_ready,
        output in_ready, out_valid, out_byte, out_addr, out_last, illegal_cnt
    );
endinterface

// File: rtl/instr_encoder.sv
// Serializes one decoded instruction into OP, REG, [IMM1], [IMM2] bytes, each tagged with a program address.
// Latency: first byte valid 1 cycle after accept; one byte per cycle while out_ready is high.
// Backpressure: out_ready low holds byte/addr/last stable; in_ready is low until the last byte is taken.
module instr_encoder #(
    parameter int              ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic            clk,
    input  logic            sync_rst,
    instr_encoder_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_REG,
        S_IMM1,
        S_IMM2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [4:0]        opcode_q;
    logic [2:0]        dst_q;
    logic [2:0]        src1_q;
    logic [2:0]        src2_q;
    logic              hasimm1_q;
    logic [7:0]        imm1_q;
    logic              hasimm2_q;
    logic [7:0]        imm2_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        ill_q;

    logic              accept;
    logic              legal;
    logic              fire;

    // 0x1A-0x1E are the only holes in the opcode map.
    assign legal  = (bus.in_opcode <= 5'h19) || (bus.in_opcode == 5'h1F);
    assign accept = (state == S_IDLE) && bus.in_valid;
    // Every non-idle state presents a byte, so a handshake is simply "busy and ready".
    assign fire   = (state != S_IDLE) && bus.out_ready;

    assign bus.out_addr    = addr_q;
    assign bus.illegal_cnt = ill_q;

    // State register; reset abandons any partially emitted instruction.
    always_ff @(posedge clk or negedge sync_rst) begin
        if (!sync_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-state byte selection.
    always_comb begin
        state_nxt    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_byte  = 8'h00;
        bus.out_last  = 1'b0;
        case (state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && legal) begin
                    state_nxt = S_OP;
                end
            end
            S_OP: begin
                bus.out_valid = 1'b1;
                bus.out_byte  = {dst_q, opcode_q};
                if (bus.out_ready) begin
                    state_nxt = S_REG;
                end
            end
            S_REG: begin
                bus.out_valid = 1'b1;
                bus.out_byte  = {hasimm1_q, hasimm2_q, src1_q, src2_q};
                bus.out_last  = !hasimm1_q && !hasimm2_q;
                if (bus.out_ready) begin
                    if (hasimm1_q) begin
                        state_nxt = S_IMM1;
                    end else if (hasimm2_q) begin
                        state_nxt = S_IMM2;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_IMM1: begin
                bus.out_valid = 1'b1;
                bus.out_byte  = imm1_q;
                bus.out_last  = !hasimm2_q;
                if (bus.out_ready) begin
                    state_nxt = hasimm2_q ? S_IMM2 : S_IDLE;
                end
            end
            S_IMM2: begin
                bus.out_valid = 1'b1;
                bus.out_byte  = imm2_q;
                bus.out_last  = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the instruction at accept so later input changes cannot leak into the stream.
    always_ff @(posedge clk or negedge sync_rst) begin
        if (!sync_rst) begin
            opcode_q  <= '0;
            dst_q     <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            hasimm1_q <= 1'b0;
            imm1_q    <= '0;
            hasimm2_q <= 1'b0;
            imm2_q    <= '0;
        end else if (accept) begin
            opcode_q  <= bus.in_opcode;
            dst_q     <= bus.in_dst;
            src1_q    <= bus.in_src1;
            src2_q    <= bus.in_src2;
            hasimm1_q <= bus.in_hasimm1;
            imm1_q    <= bus.in_imm1;
            hasimm2_q <= bus.in_hasimm2;
            imm2_q    <= bus.in_imm2;
        end
    end

    // Program address: reload only while idle, otherwise advance per byte and wrap silently.
    always_ff @(posedge clk or negedge sync_rst) begin
        if (!sync_rst) begin
            addr_q <= BASE_ADDR;
        end else if ((state == S_IDLE) && bus.addr_clr) begin
            addr_q <= BASE_ADDR;
        end else if (fire) begin
            addr_q <= addr_q + 1'b1;
        end
    end

    // Saturating count of rejected opcodes.
    always_ff @(posedge clk or negedge sync_rst) begin
        if (!sync_rst) begin
            ill_q <= '0;
        end else if (accept && !legal && (ill_q != 8'hFF)) begin
            ill_q <= ill_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: model pushes expected bytes, a monitor pops on each handshake.
// Latency: expects first byte one cycle after accept.
// Backpressure: random and directed out_ready stalls, checked for stable outputs.
module tb_instr_encoder;

    logic clk;
    logic sync_rst;
    logic bp_en;
    logic rnd_rdy;
    logic man_rdy;

    typedef struct packed {
        logic [7:0]  b;
        logic [15:0] a;
        logic        l;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_addr;
    int          m_ill;
    int          errors;
    int          checks;

    instr_encoder_if #(.ADDR_W(16)) u_if ();
    instr_encoder_if #(.ADDR_W(16)) u_if2 ();

    assign u_if.out_ready  = bp_en ? rnd_rdy : man_rdy;
    assign u_if2.out_ready = 1'b1;

    instr_encoder #(.ADDR_W(16), .BASE_ADDR(16'h0000)) u_dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .bus      (u_if)
    );

    instr_encoder #(.ADDR_W(16), .BASE_ADDR(16'hFFFF)) u_dut2 (
        .clk      (clk),
        .sync_rst (sync_rst),
        .bus      (u_if2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Random out_ready, updated just after each active edge.
    initial begin
        rnd_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rnd_rdy = ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: compares each handshaked byte with the scoreboard and checks stall stability.
    initial begin
        logic       prev_stall;
        logic [7:0] pb;
        logic [15:0] pa;
        logic       pl;
        exp_t       e;
        prev_stall = 1'b0;
        pb = '0;
        pa = '0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (!sync_rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", {31'd0, u_if.out_valid}, 32'd1);
                    chk("hold_byte", {24'd0, u_if.out_byte}, {24'd0, pb});
                    chk("hold_addr", {16'd0, u_if.out_addr}, {16'd0, pa});
                    chk("hold_last", {31'd0, u_if.out_last}, {31'd0, pl});
                end
                if (u_if.out_valid && sb.size() == 0) begin
                    chk("spurious_valid", 32'd1, 32'd0);
                end else if (u_if.out_valid && u_if.out_ready) begin
                    e = sb.pop_front();
                    chk("byte", {24'd0, u_if.out_byte}, {24'd0, e.b});
                    chk("addr", {16'd0, u_if.out_addr}, {16'd0, e.a});
                    chk("last", {31'd0, u_if.out_last}, {31'd0, e.l});
                end
                prev_stall = u_if.out_valid && !u_if.out_ready;
                pb = u_if.out_byte;
                pa = u_if.out_addr;
                pl = u_if.out_last;
            end
        end
    end

    // Present one instruction for one cycle once the encoder is idle, and record what it should produce.
    task automatic send(input logic [4:0] op, input logic [2:0] d, input logic [2:0] s1,
                        input logic [2:0] s2, input logic h1, input logic [7:0] i1,
                        input logic h2, input logic [7:0] i2, input logic clr);
        logic [7:0] q[$];
        int         v;
        int         n;
        int         k;
        exp_t       e;
        k = 0;
        while (!u_if.in_ready && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!u_if.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        u_if.in_opcode  = op;
        u_if.in_dst     = d;
        u_if.in_src1    = s1;
        u_if.in_src2    = s2;
        u_if.in_hasimm1 = h1;
        u_if.in_imm1    = i1;
        u_if.in_hasimm2 = h2;
        u_if.in_imm2    = i2;
        u_if.addr_clr   = clr;
        u_if.in_valid   = 1'b1;
        if (clr) m_addr = 16'h0000;
        if (int'(op) <= 25 || int'(op) == 31) begin
            v = int'(d) * 32 + int'(op);
            q.push_back(v[7:0]);
            v = int'(h1) * 128 + int'(h2) * 64 + int'(s1) * 8 + int'(s2);
            q.push_back(v[7:0]);
            if (h1) q.push_back(i1);
            if (h2) q.push_back(i2);
            n = q.size();
            for (int i = 0; i < n; i++) begin
                e.b = q[i];
                e.a = m_addr;
                e.l = (i == n - 1);
                sb.push_back(e);
                m_addr = m_addr + 16'd1;
            end
        end else begin
            m_ill = (m_ill < 255) ? m_ill + 1 : 255;
        end
        @(posedge clk);
        #1;
        u_if.in_valid   = 1'b0;
        u_if.addr_clr   = 1'b0;
        u_if.in_opcode  = 5'($urandom);
        u_if.in_dst     = 3'($urandom);
        u_if.in_src1    = 3'($urandom);
        u_if.in_src2    = 3'($urandom);
        u_if.in_hasimm1 = 1'($urandom);
        u_if.in_imm1    = 8'($urandom);
        u_if.in_hasimm2 = 1'($urandom);
        u_if.in_imm2    = 8'($urandom);
    endtask

    // Wait until every expected byte has been handshaked, then confirm the encoder is idle.
    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        chk("idle_in_ready", {31'd0, u_if.in_ready}, 32'd1);
        chk("idle_out_valid", {31'd0, u_if.out_valid}, 32'd0);
    endtask

    task automatic do_reset();
        sync_rst = 1'b0;
        sb.delete();
        m_addr = 16'h0000;
        m_ill  = 0;
        repeat (2) @(posedge clk);
        #1;
        sync_rst = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_addr = 16'h0000;
        m_ill  = 0;
        bp_en  = 1'b0;
        man_rdy = 1'b1;
        sync_rst = 1'b0;
        u_if.in_valid = 1'b0;   u_if.in_opcode = '0;  u_if.in_dst = '0;
        u_if.in_src1 = '0;      u_if.in_src2 = '0;    u_if.in_hasimm1 = 1'b0;
        u_if.in_imm1 = '0;      u_if.in_hasimm2 = 1'b0; u_if.in_imm2 = '0;
        u_if.addr_clr = 1'b0;
        u_if2.in_valid = 1'b0;  u_if2.in_opcode = '0; u_if2.in_dst = '0;
        u_if2.in_src1 = '0;     u_if2.in_src2 = '0;   u_if2.in_hasimm1 = 1'b0;
        u_if2.in_imm1 = '0;     u_if2.in_hasimm2 = 1'b0; u_if2.in_imm2 = '0;
        u_if2.addr_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state (still in reset)
        chk("rst_in_ready", {31'd0, u_if.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, u_if.out_valid}, 32'd0);
        chk("rst_out_byte", {24'd0, u_if.out_byte}, 32'd0);
        chk("rst_out_last", {31'd0, u_if.out_last}, 32'd0);
        chk("rst_out_addr", {16'd0, u_if.out_addr}, 32'd0);
        chk("rst_illegal_cnt", {24'd0, u_if.illegal_cnt}, 32'd0);
        chk("rst_base_addr2", {16'd0, u_if2.out_addr}, 32'h0000FFFF);
        sync_rst = 1'b1;
        @(posedge clk);
        #1;

        // Address wrap on the encoder whose base is the top address
        u_if2.in_opcode = 5'h1F;
        u_if2.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        u_if2.in_valid = 1'b0;
        chk("wrap_op_valid", {31'd0, u_if2.out_valid}, 32'd1);
        chk("wrap_op_byte", {24'd0, u_if2.out_byte}, 32'h1F);
        chk("wrap_op_addr", {16'd0, u_if2.out_addr}, 32'h0000FFFF);
        @(posedge clk);
        #1;
        chk("wrap_reg_byte", {24'd0, u_if2.out_byte}, 32'h00);
        chk("wrap_reg_addr", {16'd0, u_if2.out_addr}, 32'h00000000);
        chk("wrap_reg_last", {31'd0, u_if2.out_last}, 32'd1);
        @(posedge clk);
        #1;
        chk("wrap_idle", {31'd0, u_if2.in_ready}, 32'd1);
        chk("wrap_next_addr", {16'd0, u_if2.out_addr}, 32'h00000001);

        // 0x21@0, 0x50@1, 0x05@2 (last)
        send(5'h01, 3'd1, 3'd2, 3'd0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0);
        drain();

        // addr_clr together with accept: 0x08, 0xC0, 0x12, 0x34 at 0..3
        send(5'h08, 3'd0, 3'd0, 3'd0, 1'b1, 8'h12, 1'b1, 8'h34, 1'b1);
        drain();

        // Halt: 0x1F, 0x00 then address 2
        do_reset();
        send(5'h1F, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        drain();
        chk("halt_addr", {16'd0, u_if.out_addr}, 32'd2);

        // Three-cycle stall on REG, with addr_clr ignored while busy
        man_rdy = 1'b0;
        send(5'h05, 3'd3, 3'd4, 3'd5, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
        man_rdy = 1'b1;
        @(posedge clk);
        #1;
        man_rdy = 1'b0;
        u_if.addr_clr = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            u_if.addr_clr = 1'b0;
        end
        man_rdy = 1'b1;
        drain();
        chk("busy_clr_ignored", {16'd0, u_if.out_addr}, {16'd0, m_addr});

        // Illegal opcode rejection and saturation
        send(5'h1A, 3'd1, 3'd1, 3'd1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("illegal_cnt_1", {24'd0, u_if.illegal_cnt}, 32'd1);
        chk("illegal_in_ready", {31'd0, u_if.in_ready}, 32'd1);
        for (int i = 0; i < 256; i++) begin
            send(5'($urandom_range(26, 30)), 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        end
        chk("illegal_cnt_sat", {24'd0, u_if.illegal_cnt}, 32'd255);
        chk("illegal_model", {24'd0, u_if.illegal_cnt}, m_ill);

        // Reset while the IMM1 byte is stalled
        man_rdy = 1'b0;
        send(5'h02, 3'd2, 3'd3, 3'd1, 1'b1, 8'h77, 1'b1, 8'h88, 1'b0);
        man_rdy = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        man_rdy = 1'b0;
        chk("imm1_byte", {24'd0, u_if.out_byte}, 32'h77);
        sync_rst = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, u_if.out_valid}, 32'd0);
        chk("midrst_out_addr", {16'd0, u_if.out_addr}, 32'd0);
        chk("midrst_in_ready", {31'd0, u_if.in_ready}, 32'd1);
        sb.delete();
        m_addr = 16'h0000;
        m_ill  = 0;
        @(posedge clk);
        #1;
        sync_rst = 1'b1;
        man_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_bytes", {31'd0, u_if.out_valid}, 32'd0);

        // Randomized traffic with random backpressure and occasional addr_clr
        bp_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send(5'($urandom_range(0, 31)), 3'($urandom), 3'($urandom), 3'($urandom),
                 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                 ($urandom_range(0, 9) == 0));
        end
        drain();
        bp_en = 1'b0;
        chk("rand_illegal_cnt", {24'd0, u_if.illegal_cnt}, m_ill);
        chk("rand_final_addr", {16'd0, u_if.out_addr}, {16'd0, m_addr});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
